// File: rtl/cpu_arb_pkg.sv
// Shared widths, types and helpers for the cpu stream arbiter.
package cpu_arb_pkg;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 32;

  typedef logic [DATA_W-1:0] data_t;

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  // Doubling the vector turns the wrap-around scan into a plain right shift.
  assign rot = N'({req, req} >> ptr);

  always_comb begin
    any = 1'b0;
    off = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!any && rot[j]) begin
        any = 1'b1;
        off = IW'(j);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IW+1)'(N))
      sum = sum - (IW+1)'(N);
    idx = sum[IW-1:0];
    gnt = '0;
    for (int unsigned k = 0; k < N; k++)
      gnt[k] = any && (idx == IW'(k));
  end

endmodule

// File: rtl/cpu_stream_arbiter.sv
// Round-robin merge of CPU_NB 64-bit streams into one registered, index-tagged output.
module cpu_stream_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int CPU_NB = 4,
  parameter int IDX_W  = idx_w(CPU_NB)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CPU_NB-1:0]        req_vld,
  input  logic [CPU_NB*DATA_W-1:0] req_data,
  output logic [CPU_NB-1:0]        req_rdy,
  input  logic [CPU_NB-1:0]        done_in,
  output logic                     out_vld,
  output logic [DATA_W-1:0]        out_data,
  output logic [IDX_W-1:0]         out_idx,
  input  logic                     out_rdy,
  output logic [CNT_W-1:0]         xfer_cnt,
  output logic                     all_done
);

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  ptr_nxt;
  logic [CPU_NB-1:0] done_seen;
  logic [CNT_W-1:0]  cnt_q;
  logic              pick_any;
  logic [CPU_NB-1:0] pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              slot_free;
  logic              accept;
  data_t             sel_data;

  rr_pick #(
    .N  (CPU_NB),
    .IW (IDX_W)
  ) u_pick (
    .req (req_vld),
    .ptr (rr_ptr),
    .any (pick_any),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign slot_free = !out_vld || out_rdy;
  // Gated by rst_n so no producer sees an accept while the block is held in reset.
  assign req_rdy   = (rst_n && slot_free) ? pick_gnt : '0;
  assign accept    = rst_n && slot_free && pick_any;
  assign sel_data  = req_data[DATA_W*pick_idx +: DATA_W];
  assign xfer_cnt  = cnt_q;

  always_comb begin
    if (pick_idx == IDX_W'(CPU_NB-1))
      ptr_nxt = '0;
    else
      ptr_nxt = pick_idx + IDX_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_idx  <= '0;
      rr_ptr   <= '0;
    end else if (accept) begin
      out_vld  <= 1'b1;
      out_data <= sel_data;
      out_idx  <= pick_idx;
      rr_ptr   <= ptr_nxt;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (out_vld && out_rdy)
      cnt_q <= cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_seen <= '0;
      all_done  <= 1'b0;
    end else begin
      done_seen <= done_seen | done_in;
      all_done  <= (&done_seen) && !(|req_vld) && !out_vld;
    end
  end

endmodule

// File: tb/tb_cpu_stream_arbiter.sv
// Directed, table-driven bench for cpu_stream_arbiter with CPU_NB=4.
module tb_cpu_stream_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_vld;
  logic [255:0] req_data;
  logic [3:0]   req_rdy;
  logic [3:0]   done_in;
  logic         out_vld;
  logic [63:0]  out_data;
  logic [1:0]   out_idx;
  logic         out_rdy;
  logic [31:0]  xfer_cnt;
  logic         all_done;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]   vld;
    logic [255:0] data;
    logic         rdy;
    logic [3:0]   e_rdy;
    logic         e_ovld;
    logic [1:0]   e_idx;
    logic [63:0]  e_data;
    logic [31:0]  e_cnt;
  } vec_t;

  vec_t vecs[20];

  localparam logic [255:0] DA = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
  localparam logic [255:0] DB = {64'hB3, 64'h0123456789ABCDEF, 64'hB1, 64'hB0};

  cpu_stream_arbiter #(.CPU_NB(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_vld  (req_vld),
    .req_data (req_data),
    .req_rdy  (req_rdy),
    .done_in  (done_in),
    .out_vld  (out_vld),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_rdy  (out_rdy),
    .xfer_cnt (xfer_cnt),
    .all_done (all_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{4'b1111, DA, 1'b1, 4'b0001, 1'b1, 2'd0, 64'hA0, 32'd0};
    vecs[1]  = '{4'b1111, DA, 1'b1, 4'b0010, 1'b1, 2'd1, 64'hA1, 32'd1};
    vecs[2]  = '{4'b1111, DA, 1'b1, 4'b0100, 1'b1, 2'd2, 64'hA2, 32'd2};
    vecs[3]  = '{4'b1111, DA, 1'b1, 4'b1000, 1'b1, 2'd3, 64'hA3, 32'd3};
    vecs[4]  = '{4'b1111, DA, 1'b1, 4'b0001, 1'b1, 2'd0, 64'hA0, 32'd4};
    vecs[5]  = '{4'b1111, DA, 1'b1, 4'b0010, 1'b1, 2'd1, 64'hA1, 32'd5};
    vecs[6]  = '{4'b1111, DA, 1'b1, 4'b0100, 1'b1, 2'd2, 64'hA2, 32'd6};
    vecs[7]  = '{4'b1111, DA, 1'b1, 4'b1000, 1'b1, 2'd3, 64'hA3, 32'd7};
    vecs[8]  = '{4'b0000, DA, 1'b1, 4'b0000, 1'b0, 2'd3, 64'hA3, 32'd8};
    vecs[9]  = '{4'b0100, DB, 1'b1, 4'b0100, 1'b1, 2'd2, 64'h0123456789ABCDEF, 32'd8};
    vecs[10] = '{4'b1010, DB, 1'b1, 4'b1000, 1'b1, 2'd3, 64'hB3, 32'd9};
    vecs[11] = '{4'b0010, DB, 1'b1, 4'b0010, 1'b1, 2'd1, 64'hB1, 32'd10};
    for (int i = 12; i < 17; i++)
      vecs[i] = '{4'b1001, DB, 1'b0, 4'b0000, 1'b1, 2'd1, 64'hB1, 32'd10};
    vecs[17] = '{4'b1001, DB, 1'b1, 4'b1000, 1'b1, 2'd3, 64'hB3, 32'd11};
    vecs[18] = '{4'b0001, DB, 1'b1, 4'b0001, 1'b1, 2'd0, 64'hB0, 32'd12};
    vecs[19] = '{4'b0000, DB, 1'b1, 4'b0000, 1'b0, 2'd0, 64'hB0, 32'd13};

    rst_n    = 1'b0;
    req_vld  = 4'b1111;
    req_data = DA;
    done_in  = '0;
    out_rdy  = 1'b0;
    cyc();
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_idx", 64'(out_idx), 64'd0);
    chk("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
    chk("rst_all_done", 64'(all_done), 64'd0);
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);

    // Reset arriving mid-stall
    @(negedge clk);
    rst_n   = 1'b1;
    req_vld = 4'b0010;
    out_rdy = 1'b0;
    #1 chk("t1_first_grant", 64'(req_rdy), 64'b0010);
    cyc();
    chk("t1_held_vld", 64'(out_vld), 64'd1);
    @(negedge clk);
    req_vld = 4'b1111;
    #1 chk("t1_stall_rdy", 64'(req_rdy), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_vld", 64'(out_vld), 64'd0);
    chk("t1_rst_cnt", 64'(xfer_cnt), 64'd0);
    chk("t1_rst_rdy", 64'(req_rdy), 64'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    req_vld = 4'b0110;
    out_rdy = 1'b1;
    #1 chk("t1_post_rst_grant", 64'(req_rdy), 64'b0010);
    cyc();
    chk("t1_post_rst_idx", 64'(out_idx), 64'd1);

    // Fresh reset so the table starts from rr_ptr=0 and xfer_cnt=0
    @(negedge clk);
    req_vld = '0;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_vld  = vecs[i].vld;
      req_data = vecs[i].data;
      out_rdy  = vecs[i].rdy;
      #1 chk($sformatf("v%0d_req_rdy", i), 64'(req_rdy), 64'(vecs[i].e_rdy));
      cyc();
      chk($sformatf("v%0d_out_vld", i), 64'(out_vld), 64'(vecs[i].e_ovld));
      chk($sformatf("v%0d_out_idx", i), 64'(out_idx), 64'(vecs[i].e_idx));
      chk($sformatf("v%0d_out_data", i), out_data, vecs[i].e_data);
      chk($sformatf("v%0d_xfer_cnt", i), 64'(xfer_cnt), 64'(vecs[i].e_cnt));
    end

    // Done tracking: staggered single-cycle pulses, no traffic
    begin
      logic [3:0] pulses [4];
      pulses[0] = 4'b0001;
      pulses[1] = 4'b0100;
      pulses[2] = 4'b1000;
      pulses[3] = 4'b0010;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        req_vld = '0;
        done_in = pulses[i];
        cyc();
        chk($sformatf("t5_pulse%0d_all_done", i), 64'(all_done), 64'd0);
        @(negedge clk);
        done_in = '0;
        cyc();
        chk($sformatf("t5_gap%0d_all_done", i), 64'(all_done), (i == 3) ? 64'd1 : 64'd0);
      end
    end
    cyc();
    chk("t5_all_done_stays", 64'(all_done), 64'd1);
    @(negedge clk);
    req_vld = 4'b0001;
    out_rdy = 1'b0;
    cyc();
    chk("t5_late_req_all_done", 64'(all_done), 64'd0);
    chk("t5_late_req_vld", 64'(out_vld), 64'd1);

    // Counter wrap via backdoor preload while stalled
    @(negedge clk);
    req_vld = '0;
    out_rdy = 1'b0;
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    #1 chk("t6_preload", 64'(xfer_cnt), 64'hFFFF_FFFF);
    cyc();
    chk("t6_stall_hold", 64'(xfer_cnt), 64'hFFFF_FFFF);
    @(negedge clk);
    out_rdy = 1'b1;
    cyc();
    chk("t6_wrap", 64'(xfer_cnt), 64'd0);
    chk("t6_drain_vld", 64'(out_vld), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
